// File: rtl/bomb_sprite_drawer_if.sv
// Signal bundle between the bomb sprite drawer and its surroundings:
// the bomb table query, the sprite ROM and the VGA plot port.
interface bomb_sprite_drawer_if #(
  parameter int COLOUR_W = 9
);
  logic                start;
  logic [2:0]          bomb_id;
  logic [17:0]         bomb_info;
  logic [7:0]          sprite_addr;
  logic [COLOUR_W-1:0] sprite_pixel;
  logic [8:0]          x;
  logic [7:0]          y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                busy;
  logic                done;

  modport master (
    input  start, bomb_info, sprite_pixel,
    output bomb_id, sprite_addr, x, y, colour, plot, busy, done
  );

  modport slave (
    output start, bomb_info, sprite_pixel,
    input  bomb_id, sprite_addr, x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/bomb_sprite_drawer.sv
// Bomb sprite drawer: scans every bomb slot and streams a 16x16 sprite
// from the sprite ROM to the VGA plot port for each enabled bomb.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for start
// LOAD    | query slot id_q; latch position if enabled, else skip
// DRAW    | issue ROM addresses 0..255 for the current bomb
// FLUSH   | emit the final pixel still in the ROM pipeline
// DONE    | one-cycle completion pulse
module bomb_sprite_drawer #(
  parameter int                    NUM_BOMBS   = 6,
  parameter int                    COLOUR_W    = 9,
  parameter logic [COLOUR_W-1:0]   TRANSPARENT = 9'h1FF
) (
  input  logic                   clk,
  input  logic                   resetn,
  bomb_sprite_drawer_if.master   bus
);

  localparam logic [2:0] LAST_ID = 3'(NUM_BOMBS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAW,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] id_q, id_d;
  logic [8:0] bx_q, bx_d;
  logic [7:0] by_q, by_d;
  logic [7:0] cnt_q, cnt_d;
  // Address of the pixel the ROM is returning this cycle, and whether it is live.
  logic [7:0] pix_cnt_q, pix_cnt_d;
  logic       pix_vld_q, pix_vld_d;

  // State and datapath registers; async reset clears everything, so plot drops at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      id_q      <= '0;
      bx_q      <= '0;
      by_q      <= '0;
      cnt_q     <= '0;
      pix_cnt_q <= '0;
      pix_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      cnt_q     <= cnt_d;
      pix_cnt_q <= pix_cnt_d;
      pix_vld_q <= pix_vld_d;
    end
  end

  // Next-state logic: slot scan, sprite address sweep and ROM-latency tracking.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    bx_d      = bx_q;
    by_d      = by_q;
    cnt_d     = cnt_q;
    pix_cnt_d = pix_cnt_q;
    pix_vld_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          id_d    = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.bomb_info[0]) begin
          bx_d    = bus.bomb_info[9:1];
          by_d    = bus.bomb_info[17:10];
          cnt_d   = '0;
          state_d = S_DRAW;
        end else if (id_q == LAST_ID) begin
          state_d = S_DONE;
        end else begin
          id_d = id_q + 3'd1;
        end
      end
      S_DRAW: begin
        pix_cnt_d = cnt_q;
        pix_vld_d = 1'b1;
        cnt_d     = cnt_q + 8'd1;
        if (cnt_q == 8'hFF) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (id_q == LAST_ID) begin
          state_d = S_DONE;
        end else begin
          id_d    = id_q + 3'd1;
          state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Plot outputs line up with the ROM data, one cycle behind the address.
  always_comb begin
    bus.bomb_id     = id_q;
    bus.sprite_addr = cnt_q;
    bus.x           = bx_q + {5'd0, pix_cnt_q[3:0]};
    bus.y           = by_q + {4'd0, pix_cnt_q[7:4]};
    bus.colour      = pix_vld_q ? bus.sprite_pixel : '0;
    bus.plot        = pix_vld_q && (bus.sprite_pixel != TRANSPARENT);
    bus.busy        = (state_q != S_IDLE);
    bus.done        = (state_q == S_DONE);
  end

endmodule
